// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin arbiter that shares one 8-bit UART transmitter among
//             NUM_REQ byte producers. Each frame is sequenced as follows:
//               1. Grant the winner, then pulse tx_start and ack.
//               2. Hold tx_data until tx_done.
//               3. Insert GUARD_CLKS idle clocks before the next grant.
//  Ports    : tx_clk    in   clock (transmitter clock domain)
//             rst       in   synchronous reset, active-high
//             req       in   [NUM_REQ]   per-requester request
//             req_data  in   [8*NUM_REQ] requester i byte at [8i+7:8i]
//             ack       out  [NUM_REQ]   one-cycle accept pulse
//             tx_start  out  one-cycle start pulse to the transmitter
//             tx_data   out  [8] byte to the transmitter, held for the frame
//             tx_busy   in   transmitter busy, blocks new grants
//             tx_done   in   one-cycle end-of-frame pulse
//             grant_id  out  [ID_W] last or current owner
//             active    out  high from tx_start through the last guard clock
//             tx_err    out  one-cycle watchdog pulse
//  Options  : `define TX_TIMEOUT_EN adds a WAIT_DONE watchdog of TIMEOUT_CLKS
//             clocks. Without it, tx_err is constant 0 and WAIT_DONE waits
//             indefinitely.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GUARD_CLKS   = 521,
    parameter int TIMEOUT_CLKS = 8192
) (
    input  logic                 tx_clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                 active,
    output logic                 tx_err
);

    localparam int ID_W = $clog2(NUM_REQ);

    // One counter serves both the guard gap and the watchdog, so it is sized
    // for the larger of the two limits.
    localparam int CNT_MAX = (GUARD_CLKS > TIMEOUT_CLKS) ? GUARD_CLKS : TIMEOUT_CLKS;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam bit               HAS_GUARD  = (GUARD_CLKS != 0);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CLKS > 0) ? GUARD_CLKS - 1 : 0);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [ID_W-1:0]    LAST_RST = ID_W'(NUM_REQ - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_DONE = 2'd1;
    localparam logic [1:0] ST_GUARD     = 2'd2;

    logic [1:0]         state_q,    state_d;
    logic [NUM_REQ-1:0] ack_q,      ack_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q,  tx_data_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    last_q,     last_d;
    logic               active_q,   active_d;
    logic               tx_err_q,   tx_err_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;

    logic [ID_W-1:0]    win_id;
    logic               grant;
    logic               guard_end;
    logic               timeout_hit;

    // ------------------------------------------------------------------
    // Round-robin pick: scan last+1, last+2, ... (mod NUM_REQ). The loop
    // walks from the farthest candidate to the nearest, so the nearest
    // asserted request is the one that remains assigned.
    // ------------------------------------------------------------------
    always_comb begin
        int              idx;
        logic [ID_W-1:0] sel;
        idx    = 0;
        sel    = '0;
        win_id = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(last_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = ID_W'(idx);
            if (req[sel]) begin
                win_id = sel;
            end
        end
    end

    assign grant     = (state_q == ST_IDLE) && (|req) && !tx_busy;
    assign guard_end = (cnt_q == GUARD_LAST);

`ifdef TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CLKS - 1);
    // A tx_done arriving on the limit cycle wins; that frame is a success.
    assign timeout_hit = (state_q == ST_WAIT_DONE) && !tx_done && (cnt_q == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            grant_id_q <= '0;
            last_q     <= LAST_RST;
            active_q   <= 1'b0;
            tx_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            active_q   <= active_d;
            tx_err_q   <= tx_err_d;
            cnt_q      <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done || timeout_hit) begin
                    state_d = HAS_GUARD ? ST_GUARD : ST_IDLE;
                end
            end
            ST_GUARD: begin
                if (guard_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values (registered above)
    // ------------------------------------------------------------------
    always_comb begin
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_err_d   = 1'b0;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        active_d   = active_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                active_d = 1'b0;
                cnt_d    = '0;
                if (grant) begin
                    ack_d      = ONE_HOT0 << win_id;
                    tx_start_d = 1'b1;
                    tx_data_d  = req_data[{win_id, 3'b000} +: 8];
                    grant_id_d = win_id;
                    last_d     = win_id;
                    active_d   = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done || timeout_hit) begin
                    cnt_d    = '0;
                    active_d = HAS_GUARD;
                    tx_err_d = timeout_hit;
                end else begin
`ifdef TX_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`else
                    cnt_d = cnt_q;
`endif
                end
            end
            ST_GUARD: begin
                if (guard_end) begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

    assign ack      = ack_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign active   = active_q;
    assign tx_err   = tx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Directed self-checking bench for uart_tx_arbiter
//             (NUM_REQ=4, GUARD_CLKS=4, TIMEOUT_CLKS=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int GUARD_CLKS   = 4;
    localparam int TIMEOUT_CLKS = 16;
    localparam int ID_W         = 2;

    logic                 tx_clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic [ID_W-1:0]      grant_id;
    logic                 active;
    logic                 tx_err;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .GUARD_CLKS   (GUARD_CLKS),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) dut (
        .tx_clk   (tx_clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .grant_id (grant_id),
        .active   (active),
        .tx_err   (tx_err)
    );

    always #5 tx_clk = ~tx_clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One-cycle tx_done; returns in the first cycle after the done cycle.
    task automatic send_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // From a tx_start cycle S: raise tx_done in cycle S+10.
    task automatic run_frame();
        repeat (10) tick();
        send_done();
    endtask

    // Ticks until tx_start is seen or 50 clocks have passed.
    task automatic wait_start(output int n);
        n = 0;
        while (tx_start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ack, tx_start, tx_err, active} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ack=%b start=%b err=%b active=%b want all 0",
                     ack, tx_start, tx_err, active);
        end
        checks++;
        if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: got data=%h gid=%0d want 00 / 0", tx_data, grant_id);
        end
        // tx_done while idle must not start anything
        send_done();
        tick();
        checks++;
        if (active !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_done_ignored: got active=%b start=%b want 0/0", active, tx_start);
        end
    endtask

    task automatic test_single();
        req_data = 32'h0000_00A5;
        req      = 4'b0001;
        tick();
        checks++;
        if (tx_start !== 1'b1 || ack !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got start=%b ack=%b want 1 / 0001", tx_start, ack);
        end
        checks++;
        if (tx_data !== 8'hA5 || grant_id !== 2'd0 || active !== 1'b1) begin
            errors++;
            $display("FAIL single_data: got data=%h gid=%0d active=%b want a5 / 0 / 1",
                     tx_data, grant_id, active);
        end
        req      = 4'b0000;
        req_data = 32'h0;
        tick();
        checks++;
        if (tx_start !== 1'b0 || ack !== 4'b0000 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold: got start=%b ack=%b data=%h want 0 / 0000 / a5",
                     tx_start, ack, tx_data);
        end
        repeat (9) tick();
        send_done();
        repeat (3) tick();
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL single_guard_active: got %b want 1 (4 clocks after done)", active);
        end
        tick();
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL single_active_drop: got %b want 0 (5 clocks after done)", active);
        end
    endtask

    task automatic test_round_robin();
        int n;
        logic [ID_W-1:0] exp_id;
        logic [7:0]      exp_data;
        do_reset();
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            exp_id   = ID_W'(f % 4);
            exp_data = 8'h11 * 8'(f % 4 + 1);
            wait_start(n);
            checks++;
            if (tx_start !== 1'b1 || n !== ((f == 0) ? 1 : GUARD_CLKS + 1)) begin
                errors++;
                $display("FAIL rr_latency[%0d]: got start=%b after %0d clocks want 1 after %0d",
                         f, tx_start, n, (f == 0) ? 1 : GUARD_CLKS + 1);
            end
            checks++;
            if (grant_id !== exp_id || ack !== (4'b0001 << exp_id) || tx_data !== exp_data) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got gid=%0d ack=%b data=%h want %0d / %b / %h",
                         f, grant_id, ack, tx_data, exp_id, 4'b0001 << exp_id, exp_data);
            end
            run_frame();
        end
        req = 4'b0000;
        repeat (6) tick();
    endtask

    task automatic test_partial();
        int n;
        logic [ID_W-1:0] exp_seq [3] = '{2'd1, 2'd3, 2'd3};
        do_reset();
        req_data = 32'h4433_2211;
        req      = 4'b1000;
        wait_start(n);
        checks++;
        if (tx_start !== 1'b1 || grant_id !== 2'd3) begin
            errors++;
            $display("FAIL part_first: got start=%b gid=%0d want 1 / 3", tx_start, grant_id);
        end
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            run_frame();
            wait_start(n);
            checks++;
            if (tx_start !== 1'b1 || grant_id !== exp_seq[k] || ack !== (4'b0001 << exp_seq[k])) begin
                errors++;
                $display("FAIL part_grant[%0d]: got start=%b gid=%0d ack=%b want 1 / %0d",
                         k, tx_start, grant_id, ack, exp_seq[k]);
            end
            if (k == 1) req = 4'b1000;
        end
        req = 4'b0000;
        run_frame();
        repeat (6) tick();
    endtask

    task automatic test_busy();
        int bad;
        do_reset();
        req_data = 32'h0000_5A00;
        tx_busy  = 1'b1;
        req      = 4'b0010;
        bad      = 0;
        repeat (6) begin
            tick();
            if (tx_start !== 1'b0 || ack !== 4'b0000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL busy_block: got %0d cycles with start/ack want 0", bad);
        end
        tx_busy = 1'b0;
        tick();
        checks++;
        if (tx_start !== 1'b1 || ack !== 4'b0010 || grant_id !== 2'd1 || tx_data !== 8'h5A) begin
            errors++;
            $display("FAIL busy_release: got start=%b ack=%b gid=%0d data=%h want 1 / 0010 / 1 / 5a",
                     tx_start, ack, grant_id, tx_data);
        end
        req = 4'b0000;
        run_frame();
        repeat (6) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_data = 32'h0077_0011;
        req      = 4'b0001;
        tick();
        req = 4'b0000;
        repeat (3) tick();
        rst = 1'b1;
        req = 4'b0100;
        tick();
        checks++;
        if ({ack, tx_start, tx_err, active} !== 7'b0 || tx_data !== 8'h00 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL midreset_state: got ack=%b start=%b err=%b active=%b data=%h gid=%0d want zeros",
                     ack, tx_start, tx_err, active, tx_data, grant_id);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (tx_start !== 1'b1 || ack !== 4'b0100 || grant_id !== 2'd2 || tx_data !== 8'h77) begin
            errors++;
            $display("FAIL midreset_grant: got start=%b ack=%b gid=%0d data=%h want 1 / 0100 / 2 / 77",
                     tx_start, ack, grant_id, tx_data);
        end
        req = 4'b0000;
        run_frame();
        repeat (6) tick();
    endtask

`ifdef TX_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        req_data = 32'h0000_BB00 | 32'h0000_00AA;
        req      = 4'b0001;
        tick();
        req = 4'b0000;
        repeat (15) tick();
        checks++;
        if (tx_err !== 1'b0) begin
            errors++;
            $display("FAIL to_early: got tx_err=%b want 0 (15 clocks after start)", tx_err);
        end
        tick();
        checks++;
        if (tx_err !== 1'b1 || active !== 1'b1) begin
            errors++;
            $display("FAIL to_pulse: got tx_err=%b active=%b want 1 / 1 (16 clocks after start)",
                     tx_err, active);
        end
        req = 4'b0011;
        tick();
        checks++;
        if (tx_err !== 1'b0) begin
            errors++;
            $display("FAIL to_one_cycle: got tx_err=%b want 0", tx_err);
        end
        wait_start(n);
        checks++;
        if (tx_start !== 1'b1 || n !== 4 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL to_next_grant: got start=%b after %0d gid=%0d want 1 after 4 / 1",
                     tx_start, n, grant_id);
        end
        req = 4'b0000;
        run_frame();
        repeat (6) tick();
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        do_reset();
        req_data = 32'h0000_00C3;
        req      = 4'b0001;
        tick();
        req = 4'b0000;
        bad = 0;
        repeat (40) begin
            tick();
            if (tx_err !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || active !== 1'b1 || tx_data !== 8'hC3) begin
            errors++;
            $display("FAIL no_watchdog: got err_cycles=%0d active=%b data=%h want 0 / 1 / c3",
                     bad, active, tx_data);
        end
        send_done();
        repeat (4) tick();
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL no_watchdog_end: got active=%b want 0", active);
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_partial();
        test_busy();
        test_reset_mid();
`ifdef TX_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
